// File: rtl/alu_seq.sv
// alu_seq: ALU stage fed by the operand-A selector.
//   Single-cycle ADD/SUB/AND/OR/XOR/NOT/SHL/SHR/MOV. MUL is a WIDTH-cycle
//   unsigned shift-add multiply. The result, the MUL high half and the
//   {Z,N,C,V} flags are registered. Start/busy/done handshake with control.
// Ports:
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   a_i, b_i              operands
//   op_i                  opcode, captured with start_i
//   start_i               launch, honoured only in IDLE
//   flags_we_i            update flags at completion, captured with start_i
//   result_o              result (MUL: low half)
//   result_hi_o           MUL high half, 0 after other ops
//   flags_o               {Z,N,C,V}
//   busy_o                MUL in progress
//   done_o                one-cycle completion pulse
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    input  logic             start_i,
    input  logic             flags_we_i,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic [3:0]       flags_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d;
    logic [WIDTH-1:0] mcand_q, mcand_d, mplr_q, mplr_d, acc_q, acc_d;
    logic [3:0]       flags_q, flags_d;
    logic             fwe_q, fwe_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Single-cycle datapath, operating on the live inputs of the launch edge.
    logic [WIDTH:0]   sum, dif;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    always_comb begin
        sum     = {1'b0, a_i} + {1'b0, b_i};
        dif     = {1'b0, a_i} - {1'b0, b_i};
        alu_res = a_i;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_i)
            4'd0: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            4'd1: begin
                alu_res = dif[WIDTH-1:0];
                alu_c   = dif[WIDTH];   // borrow: a < b unsigned
                alu_v   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (dif[WIDTH-1] != a_i[WIDTH-1]);
            end
            4'd2: alu_res = a_i & b_i;
            4'd3: alu_res = a_i | b_i;
            4'd4: alu_res = a_i ^ b_i;
            4'd5: alu_res = ~a_i;
            4'd6: begin
                alu_res = {a_i[WIDTH-2:0], 1'b0};
                alu_c   = a_i[WIDTH-1];
            end
            4'd7: begin
                alu_res = {1'b0, a_i[WIDTH-1:1]};
                alu_c   = a_i[0];
            end
            default: alu_res = a_i;
        endcase
    end

    // One shift-add step: {acc, mplr} holds the partial product; the
    // multiplier bits are consumed from the bottom as the product shifts in.
    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] step_acc, step_mplr;

    always_comb begin
        step_sum  = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
        step_acc  = step_sum[WIDTH:1];
        step_mplr = {step_sum[0], mplr_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        hi_d    = hi_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        flags_d = flags_q;
        fwe_d   = fwe_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (op_i == 4'd8) begin
                        mcand_d = a_i;
                        mplr_d  = b_i;
                        acc_d   = '0;
                        fwe_d   = flags_we_i;
                        cnt_d   = '0;
                        state_d = S_MUL;
                    end else begin
                        res_d   = alu_res;
                        hi_d    = '0;
                        if (flags_we_i)
                            flags_d = {alu_res == '0, alu_res[WIDTH-1], alu_c, alu_v};
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL: begin
                acc_d  = step_acc;
                mplr_d = step_mplr;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    res_d = step_mplr;
                    hi_d  = step_acc;
                    if (fwe_q)
                        flags_d = {(step_acc == '0) && (step_mplr == '0),
                                   step_acc[WIDTH-1], step_acc != '0, 1'b0};
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            hi_q    <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            flags_q <= '0;
            fwe_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            flags_q <= flags_d;
            fwe_q   <= fwe_d;
            cnt_q   <= cnt_d;
        end
    end

    assign result_o    = res_q;
    assign result_hi_o = hi_q;
    assign flags_o     = flags_q;
    assign busy_o      = (state_q == S_MUL);
    assign done_o      = (state_q == S_DONE);
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven directed vectors, multi-cycle corner sequences and
// randomized ops checked against an arithmetic reference model.
module tb_alu_seq;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] a_i = '0, b_i = '0;
    logic [3:0] op_i = '0;
    logic       start_i = 1'b0, flags_we_i = 1'b0;
    logic [7:0] result_o, result_hi_o;
    logic [3:0] flags_o;
    logic       busy_o, done_o;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_flags = '0;

    alu_seq #(.WIDTH(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .a_i(a_i), .b_i(b_i), .op_i(op_i),
        .start_i(start_i), .flags_we_i(flags_we_i), .result_o(result_o),
        .result_hi_o(result_hi_o), .flags_o(flags_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b;
        logic       we;
        logic [7:0] res, hi;
        logic [3:0] flags;
    } vec_t;

    typedef struct {
        logic [7:0] res, hi;
        logic [3:0] flags;
    } ref_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode rules.
    function automatic ref_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        ref_t r;
        int ua, ub, sa, sb, full, s;
        logic c, v;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        c = 0; v = 0; r.hi = 0;
        case (op)
            0: begin full = ua + ub; r.res = full[7:0]; c = full > 255; s = sa + sb; v = (s > 127) || (s < -128); end
            1: begin full = ua - ub; r.res = full[7:0]; c = ua < ub;    s = sa - sb; v = (s > 127) || (s < -128); end
            2: r.res = a & b;
            3: r.res = a | b;
            4: r.res = a ^ b;
            5: r.res = 8'(255 - ua);
            6: begin full = ua * 2; r.res = full[7:0]; c = ua >= 128; end
            7: begin r.res = 8'(ua / 2); c = (ua % 2) == 1; end
            8: begin full = ua * ub; r.res = full[7:0]; r.hi = full[15:8]; end
            default: r.res = a;
        endcase
        if (op == 8) r.flags = {full == 0, r.hi >= 128, r.hi != 0, 1'b0};
        else         r.flags = {r.res == 0, r.res >= 128, c, v};
        return r;
    endfunction

    // Launch one op, follow it to completion and check timing and results.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic we, input logic [7:0] er,
                         input logic [7:0] eh, input logic [3:0] ef);
        int n;
        @(negedge clk_i);
        op_i = op; a_i = a; b_i = b; flags_we_i = we; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        a_i = 8'($urandom); b_i = 8'($urandom); op_i = 4'($urandom); flags_we_i = 1'($urandom);
        n = 0;
        while (!done_o && n < 40) begin
            if (busy_o) n++;
            @(posedge clk_i); #1;
        end
        chk({tag, " busy_cycles"}, n, (op == 8) ? 8 : 0);
        chk({tag, " done"}, done_o, 1);
        chk({tag, " busy_at_done"}, busy_o, 0);
        chk({tag, " result"}, result_o, er);
        chk({tag, " result_hi"}, result_hi_o, eh);
        chk({tag, " flags"}, flags_o, ef);
        @(posedge clk_i); #1;
        chk({tag, " done_single"}, done_o, 0);
        chk({tag, " result_hold"}, result_o, er);
    endtask

    vec_t tbl[16];

    initial begin
        int dn;
        ref_t r;
        logic [3:0] rop;
        logic [7:0] ra, rb;
        logic       rwe;

        tbl[0]  = '{4'd0,  8'h7F, 8'h01, 1'b1, 8'h80, 8'h00, 4'b0101};
        tbl[1]  = '{4'd1,  8'h05, 8'h05, 1'b1, 8'h00, 8'h00, 4'b1000};
        tbl[2]  = '{4'd1,  8'h03, 8'h05, 1'b1, 8'hFE, 8'h00, 4'b0110};
        tbl[3]  = '{4'd8,  8'hFF, 8'hFF, 1'b1, 8'h01, 8'hFE, 4'b0110};
        tbl[4]  = '{4'd1,  8'h05, 8'h05, 1'b1, 8'h00, 8'h00, 4'b1000};
        tbl[5]  = '{4'd6,  8'h81, 8'h00, 1'b0, 8'h02, 8'h00, 4'b1000};
        tbl[6]  = '{4'd7,  8'h01, 8'h00, 1'b1, 8'h00, 8'h00, 4'b1010};
        tbl[7]  = '{4'd2,  8'hF0, 8'h3C, 1'b1, 8'h30, 8'h00, 4'b0000};
        tbl[8]  = '{4'd3,  8'h0F, 8'h80, 1'b1, 8'h8F, 8'h00, 4'b0100};
        tbl[9]  = '{4'd4,  8'hAA, 8'hAA, 1'b1, 8'h00, 8'h00, 4'b1000};
        tbl[10] = '{4'd5,  8'h0F, 8'h00, 1'b1, 8'hF0, 8'h00, 4'b0100};
        tbl[11] = '{4'd12, 8'h5A, 8'h33, 1'b1, 8'h5A, 8'h00, 4'b0000};
        tbl[12] = '{4'd0,  8'hFF, 8'h01, 1'b1, 8'h00, 8'h00, 4'b1010};
        tbl[13] = '{4'd1,  8'h80, 8'h01, 1'b1, 8'h7F, 8'h00, 4'b0001};
        tbl[14] = '{4'd8,  8'h00, 8'h37, 1'b1, 8'h00, 8'h00, 4'b1000};
        tbl[15] = '{4'd8,  8'h10, 8'h10, 1'b1, 8'h00, 8'h01, 4'b0010};

        // Reset state
        #2;
        chk("rst result", result_o, 0);
        chk("rst result_hi", result_hi_o, 0);
        chk("rst flags", flags_o, 0);
        chk("rst busy", busy_o, 0);
        chk("rst done", done_o, 0);
        @(negedge clk_i); rst_i = 1'b0;

        for (int i = 0; i < 16; i++) begin
            do_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].we,
                  tbl[i].res, tbl[i].hi, tbl[i].flags);
            exp_flags = tbl[i].flags;
        end

        // Start requests while MUL is busy are dropped: one done, MUL result.
        @(negedge clk_i);
        op_i = 4'd8; a_i = 8'h0C; b_i = 8'h0B; flags_we_i = 1'b1; start_i = 1'b1;
        @(posedge clk_i); #1;
        op_i = 4'd0; a_i = 8'h01; b_i = 8'h01;
        dn = 0;
        for (int i = 0; i < 14; i++) begin
            if (done_o) begin
                dn++;
                start_i = 1'b0;
                chk("busy_ign result", result_o, 8'h84);
                chk("busy_ign result_hi", result_hi_o, 8'h00);
            end
            @(posedge clk_i); #1;
        end
        start_i = 1'b0;
        chk("busy_ign done_count", dn, 1);
        chk("busy_ign flags", flags_o, 4'b0000);

        // Start held through the DONE cycle is not taken.
        @(negedge clk_i);
        op_i = 4'd0; a_i = 8'h01; b_i = 8'h02; flags_we_i = 1'b1; start_i = 1'b1;
        @(posedge clk_i); #1;
        chk("doneign done", done_o, 1);
        chk("doneign result", result_o, 8'h03);
        a_i = 8'h05; b_i = 8'h05;
        @(posedge clk_i); #1;
        chk("doneign done_low", done_o, 0);
        chk("doneign result_keep", result_o, 8'h03);
        @(negedge clk_i); start_i = 1'b0;
        @(posedge clk_i); #1;
        chk("doneign no_relaunch", done_o, 0);
        chk("doneign result_final", result_o, 8'h03);
        exp_flags = 4'b0000;

        // Randomized ops against the reference model
        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(0, 15));
            if (i % 5 == 0) rop = 4'd8;
            ra = 8'($urandom); rb = 8'($urandom);
            if (i % 7 == 0) ra = 8'hFF;
            if (i % 11 == 0) rb = 8'h00;
            rwe = ($urandom_range(0, 3) != 0);
            r = model(rop, ra, rb);
            if (rwe) exp_flags = r.flags;
            do_op($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb, rwe, r.res, r.hi, exp_flags);
        end

        // Make flags nonzero, then reset 3 cycles into a MUL.
        do_op("pre_rst", 4'd7, 8'h01, 8'h00, 1'b1, 8'h00, 8'h00, 4'b1010);
        @(negedge clk_i);
        op_i = 4'd8; a_i = 8'hFF; b_i = 8'hFF; flags_we_i = 1'b1; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        chk("midmul busy_before", busy_o, 1);
        rst_i = 1'b1;
        #1;
        chk("midmul rst result", result_o, 0);
        chk("midmul rst result_hi", result_hi_o, 0);
        chk("midmul rst flags", flags_o, 0);
        chk("midmul rst busy", busy_o, 0);
        chk("midmul rst done", done_o, 0);
        @(negedge clk_i); rst_i = 1'b0;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_i); #1;
            if (done_o || busy_o) dn++;
        end
        chk("midmul no_done", dn, 0);
        chk("midmul flags_kept", flags_o, 0);
        do_op("post_rst add", 4'd0, 8'h01, 8'h01, 1'b1, 8'h02, 8'h00, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
